axil_cmd_master: RTL and testbench
==================================

// Module: axil_cmd_master
// PURPOSE
//  Synthesizable AXI4-Lite master that executes a stream of commands: WRITE, READ, WAIT_INTR and CLR_INTR.
//  It drives the zyNet slave register map (layer/neuron select, weight/bias load, result read) from an on-chip sequencer or DMA.
//  One command is in flight at a time. Every command returns exactly one response word.
//  Compared with a single-handshake driver: AW and W complete independently, a sticky interrupt latch is held, and WAIT_INTR has a timeout.
// PARAMETERS
//  ADDR_WIDTH   32   width of cmd_addr, m_axi_awaddr and m_axi_araddr
//  DATA_WIDTH   32   width of cmd_data, m_axi_wdata, m_axi_rdata and rsp_data (32 or 64)
//  TIMEOUT_W    24   width of the WAIT_INTR cycle counter
//  TIMEOUT      0    WAIT_INTR limit in cycles; 0 = wait forever
// PORTS
//  s_axi_aclk     in   1           clock
//  s_axi_aresetn  in   1           asynchronous active-low reset
//  cmd_valid      in   1           command present
//  cmd_ready      out  1           command accepted when cmd_valid & cmd_ready
//  cmd_op         in   2           00 WRITE, 01 READ, 10 WAIT_INTR, 11 CLR_INTR
//  cmd_addr       in   ADDR_WIDTH  byte address for WRITE and READ
//  cmd_data       in   DATA_WIDTH  write data
//  rsp_valid      out  1           response present; held until rsp_ready
//  rsp_ready      in   1           response consumed
//  rsp_data       out  DATA_WIDTH  READ data; 0 for all other ops
//  rsp_status     out  2           00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT
//  m_axi_aw*      out/in           awaddr[ADDR_WIDTH], awprot[3]=0, awvalid, awready
//  m_axi_w*       out/in           wdata[DATA_WIDTH], wstrb all ones, wvalid, wready
//  m_axi_b*       in/out           bresp[2], bvalid, bready
//  m_axi_ar*      out/in           araddr[ADDR_WIDTH], arprot[3]=0, arvalid, arready
//  m_axi_r*       in/out           rdata[DATA_WIDTH], rresp[2], rvalid, rready
//  intr           in   1           slave interrupt, level; synchronous to s_axi_aclk
//  busy           out  1           1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state = IDLE; all valid and ready outputs = 0 (cmd_ready becomes 1 once state is IDLE).
//   - rsp_data = 0, rsp_status = 0, intr_pend = 0, timeout counter = 0.
//   - Reset mid-transaction abandons the transaction; no response is produced.
//  cmd_ready = (state == IDLE). Command fields are captured into registers on acceptance.
//  FSM states: IDLE, WR, WR_B, RD_A, RD_R, WAIT, RSP.
//  IDLE -> on cmd accept:
//   - WRITE: go to WR; next cycle awvalid = 1 and wvalid = 1.
//   - READ: go to RD_A; next cycle arvalid = 1.
//   - WAIT_INTR: go to WAIT.
//   - CLR_INTR: clear intr_pend; go to RSP with status 00.
//  WR:
//   - awvalid drops the cycle after awready is seen; wvalid drops the cycle after wready is seen.
//   - AW and W handshakes may occur in either order or in the same cycle.
//   - Once both are done, go to WR_B.
//  WR_B: bready = 1; on bvalid capture bresp into rsp_status and go to RSP.
//  RD_A: arvalid = 1 until arready, then go to RD_R.
//  RD_R: rready = 1; on rvalid capture rdata and rresp, then go to RSP.
//  WAIT:
//   - If intr_pend = 1: clear it and go to RSP with status 00.
//   - Otherwise, if TIMEOUT != 0 and the counter reaches TIMEOUT-1: go to RSP with status 11.
//   - The counter clears on WAIT entry.
//  RSP: rsp_valid = 1; on rsp_ready go to IDLE. A new command is accepted no earlier than the next cycle.
//  Interrupt latch:
//   - intr_q is intr delayed one cycle; a rising edge is intr & ~intr_q.
//   - A rising edge sets intr_pend in any state.
//   - If an edge and a clear (CLR_INTR or WAIT consume) occur in the same cycle, the edge wins and intr_pend stays 1.
//   - A level held high produces only one edge.
//  Latency with a zero-wait slave and rsp_ready = 1:
//   - WRITE: accept at cycle 0, AW/W at 1, B at 2, rsp_valid at 3.
//   - READ: accept at 0, AR at 1, R at 2, rsp_valid at 3.
//  Valid outputs never drop before their handshake completes (AXI rule). Addresses and data stay stable while valid is high.
// STRUCTURE
//  Package axil_cmd_pkg:
//   - op encodings CMD_WRITE/READ/WAIT/CLR
//   - status codes ST_OKAY/SLVERR/DECERR/TIMEOUT
//   - FSM state enum
//   - zyNet register offsets: REG_WEIGHT=0, REG_BIAS=4, REG_RESULT=8, REG_LAYER=12, REG_NEURON=16, REG_SOFTRST=28
//  Sub-module intr_edge_latch: edge detect plus sticky pending bit; inputs set/clr, output pend; edge wins over clear.
// TESTING
//  1. WRITE addr 0x0C data 0x1, slave zero-wait -> awaddr 0x0C, wdata 0x1; rsp_valid at cycle 3; status 00, rsp_data 0.
//  2. WRITE with wready delayed 3 cycles after awready -> awvalid high for exactly 1 cycle, wvalid high for 4; one response.
//  3. READ addr 0x08, slave returns 0x7 with rvalid delayed 5 cycles -> rsp_data 0x7, status 00; a SLVERR rresp gives status 01.
//  4. intr pulses before WAIT_INTR is issued -> WAIT completes at once; a second WAIT with TIMEOUT=16 and no edge -> status 11 after 16 cycles.
//  5. CLR_INTR issued in the same cycle as an intr rising edge -> intr_pend stays 1; the next WAIT completes immediately.
//  6. Assert reset during WR with awvalid high; hold rsp_ready low for 10 cycles on a READ -> after reset all valids are 0 and state is IDLE; rsp_valid and rsp_data are held stable while stalled.

Source files
------------

// File: rtl/axil_cmd_pkg.sv
// Shared encodings for the AXI4-Lite command master: opcodes, response codes,
// controller states and the zyNet slave register offsets.
package axil_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WAIT  = 2'b10,
        CMD_CLR   = 2'b11
    } cmd_op_e;

    localparam logic [1:0] ST_OKAY    = 2'b00;
    localparam logic [1:0] ST_SLVERR  = 2'b01;
    localparam logic [1:0] ST_DECERR  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_A,
        S_RD_R,
        S_WAIT,
        S_RSP
    } state_e;

    localparam logic [31:0] REG_WEIGHT  = 32'd0;
    localparam logic [31:0] REG_BIAS    = 32'd4;
    localparam logic [31:0] REG_RESULT  = 32'd8;
    localparam logic [31:0] REG_LAYER   = 32'd12;
    localparam logic [31:0] REG_NEURON  = 32'd16;
    localparam logic [31:0] REG_SOFTRST = 32'd28;

endpackage

// File: rtl/intr_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag; a new edge beats a
// simultaneous clear so no interrupt is ever lost.
module intr_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic pend
);

    logic set_q;
    logic rise;

    assign rise = set & ~set_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            set_q <= set;
            if (rise) begin
                pend <= 1'b1;
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master executing WRITE / READ / WAIT_INTR / CLR_INTR commands,
// one at a time, each returning a single response word.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_W  = 24,
    parameter int TIMEOUT    = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_status,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    input  logic                    intr,
    output logic                    busy
);

    localparam bit                   TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST  = TIMEOUT_W'(TIMEOUT - 1);

    state_e                 state;
    logic                   aw_done;
    logic                   w_done;
    logic [TIMEOUT_W-1:0]   wait_cnt;
    logic                   intr_pend;
    logic                   intr_clr;
    logic                   aw_fire;
    logic                   w_fire;

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = '1;

    assign aw_fire  = m_axi_awvalid & m_axi_awready;
    assign w_fire   = m_axi_wvalid & m_axi_wready;
    assign intr_clr = (cmd_valid && (state == S_IDLE) && (cmd_op == CMD_CLR)) ||
                      ((state == S_WAIT) && intr_pend);

    intr_edge_latch u_intr (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .set   (intr),
        .clr   (intr_clr),
        .pend  (intr_pend)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= S_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            wait_cnt      <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_status    <= ST_OKAY;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rsp_data   <= '0;
                        rsp_status <= ST_OKAY;
                        case (cmd_op_e'(cmd_op))
                            CMD_WRITE: begin
                                m_axi_awaddr  <= cmd_addr;
                                m_axi_wdata   <= cmd_data;
                                m_axi_awvalid <= 1'b1;
                                m_axi_wvalid  <= 1'b1;
                                aw_done       <= 1'b0;
                                w_done        <= 1'b0;
                                state         <= S_WR;
                            end
                            CMD_READ: begin
                                m_axi_araddr  <= cmd_addr;
                                m_axi_arvalid <= 1'b1;
                                state         <= S_RD_A;
                            end
                            CMD_WAIT: begin
                                wait_cnt <= '0;
                                state    <= S_WAIT;
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                state     <= S_RSP;
                            end
                        endcase
                    end
                end
                // AW and W retire independently; B is only requested once both have gone
                S_WR: begin
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        m_axi_bready <= 1'b1;
                        state        <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_status   <= m_axi_bresp;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end
                S_RD_A: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_data     <= m_axi_rdata;
                        rsp_status   <= m_axi_rresp;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end
                // A pending interrupt takes priority over an expiring timeout
                S_WAIT: begin
                    if (intr_pend) begin
                        rsp_status <= ST_OKAY;
                        rsp_valid  <= 1'b1;
                        state      <= S_RSP;
                    end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                        rsp_status <= ST_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        state      <= S_RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a vector table of single commands against a
// configurable AXI-Lite slave, plus hand sequences for interrupts, reset and stalls.
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TW  = 24;
    localparam int TMO = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op    = 2'b00;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_data  = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;

    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready  = 1'b0;
    logic [1:0]      bresp   = 2'b00;
    logic            bvalid  = 1'b0;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready = 1'b0;
    logic [DW-1:0]   rdata   = '0;
    logic [1:0]      rresp   = 2'b00;
    logic            rvalid  = 1'b0;
    logic            rready;
    logic            intr    = 1'b0;
    logic            busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // slave configuration, written only by the main sequence
    int          aw_delay  = 0;
    int          w_delay   = 0;
    int          ar_delay  = 0;
    int          r_delay   = 0;
    logic [1:0]  slv_bresp = 2'b00;
    logic [1:0]  slv_rresp = 2'b00;
    logic [31:0] slv_rdata = 32'h0;

    // slave observations and private state, written only by the slave process
    logic [31:0] got_awaddr = 32'h0;
    logic [31:0] got_wdata  = 32'h0;
    logic [31:0] got_araddr = 32'h0;
    int          aw_high_total = 0;
    int          w_high_total  = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          aw_got = 0, w_got = 0, r_pend = 0;
    bit          aw_f, w_f, b_f, ar_f, r_f;

    always #5 clk = ~clk;

    axil_cmd_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT_W  (TW),
        .TIMEOUT    (TMO)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .intr          (intr),
        .busy          (busy)
    );

    // Slave model: handshakes are sampled mid-cycle, reactions are driven just after the edge.
    // Each ready rises in the (delay+1)-th cycle its valid is seen; B follows AW+W, R follows AR.
    initial begin : slave
        forever begin
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            b_f  = bvalid && bready;
            ar_f = arvalid && arready;
            r_f  = rvalid && rready;
            if (aw_f) got_awaddr = awaddr;
            if (w_f)  got_wdata  = wdata;
            if (ar_f) got_araddr = araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; r_pend = 0;
            end else begin
                if (aw_f) aw_got = 1;
                if (w_f)  w_got  = 1;
                if (b_f)  bvalid = 0;
                if (aw_got && w_got) begin
                    bvalid = 1; bresp = slv_bresp; aw_got = 0; w_got = 0;
                end
                if (awvalid) begin
                    awready = (aw_cnt >= aw_delay); aw_cnt++; aw_high_total++;
                end else begin
                    awready = 0; aw_cnt = 0;
                end
                if (wvalid) begin
                    wready = (w_cnt >= w_delay); w_cnt++; w_high_total++;
                end else begin
                    wready = 0; w_cnt = 0;
                end
                if (arvalid) begin
                    arready = (ar_cnt >= ar_delay); ar_cnt++;
                end else begin
                    arready = 0; ar_cnt = 0;
                end
                if (r_f) rvalid = 0;
                if (ar_f) begin
                    r_pend = 1; r_cnt = 0;
                end
                if (r_pend) begin
                    if (r_cnt >= r_delay) begin
                        rvalid = 1; rdata = slv_rdata; rresp = slv_rresp; r_pend = 0;
                    end else begin
                        r_cnt++;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic boundExpired(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // Issue one command from the post-edge phase; lat counts edges from acceptance (edge 1)
    // up to the edge after which rsp_valid is seen. Consumes the response if rsp_ready is high.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                                 output int lat, output logic [31:0] r_data, output logic [1:0] r_status);
        bit acc = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        lat      = 1;
        r_data   = 32'h0;
        r_status = 2'b00;
        if (!acc) begin
            boundExpired("cmd accept");
            lat = -1;
            return;
        end
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) begin
            boundExpired("rsp_valid");
            return;
        end
        r_data   = rsp_data;
        r_status = rsp_status;
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          aw_d, w_d, ar_d, r_d;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_status;
        int          exp_lat;
        int          exp_aw_hi;
        int          exp_w_hi;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int          lat;
        int          aw0, w0, seen;
        logic [31:0] r_data;
        logic [1:0]  r_status;

        //        op         addr         data           aw w ar r  bresp      rresp      rdata          exp_data       exp_status  lat aw w
        vecs[0] = '{CMD_WRITE, REG_LAYER,   32'h1,         0, 0, 0, 0, ST_OKAY,   ST_OKAY,   32'h0,         32'h0,         ST_OKAY,    3,  1, 1};
        vecs[1] = '{CMD_WRITE, REG_NEURON,  32'hA5A5_0003, 0, 3, 0, 0, ST_OKAY,   ST_OKAY,   32'h0,         32'h0,         ST_OKAY,    6,  1, 4};
        vecs[2] = '{CMD_WRITE, REG_SOFTRST, 32'h1,         2, 0, 0, 0, ST_DECERR, ST_OKAY,   32'h0,         32'h0,         ST_DECERR,  5,  3, 1};
        vecs[3] = '{CMD_READ,  REG_RESULT,  32'h0,         0, 0, 0, 5, ST_OKAY,   ST_OKAY,   32'h7,         32'h7,         ST_OKAY,    8,  0, 0};
        vecs[4] = '{CMD_READ,  REG_WEIGHT,  32'h0,         0, 0, 0, 0, ST_OKAY,   ST_OKAY,   32'hDEAD_BEEF, 32'hDEAD_BEEF, ST_OKAY,    3,  0, 0};
        vecs[5] = '{CMD_READ,  REG_BIAS,    32'h0,         0, 0, 2, 0, ST_OKAY,   ST_SLVERR, 32'h55,        32'h55,        ST_SLVERR,  5,  0, 0};
        vecs[6] = '{CMD_WRITE, REG_BIAS,    32'h12,        0, 0, 0, 0, ST_SLVERR, ST_OKAY,   32'h0,         32'h0,         ST_SLVERR,  3,  1, 1};
        vecs[7] = '{CMD_CLR,   32'h0,       32'h0,         0, 0, 0, 0, ST_OKAY,   ST_OKAY,   32'h0,         32'h0,         ST_OKAY,    1,  0, 0};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cmd_ready",  cmd_ready,  1);
        checkOutput("reset busy",       busy,       0);
        checkOutput("reset valids",     {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        checkOutput("reset rsp_data",   rsp_data,   0);
        checkOutput("reset rsp_status", rsp_status, 0);
        checkOutput("static prot/strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            aw_delay  = vecs[i].aw_d;
            w_delay   = vecs[i].w_d;
            ar_delay  = vecs[i].ar_d;
            r_delay   = vecs[i].r_d;
            slv_bresp = vecs[i].bresp;
            slv_rresp = vecs[i].rresp;
            slv_rdata = vecs[i].rdata;
            aw0 = aw_high_total;
            w0  = w_high_total;
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data, lat, r_data, r_status);
            checkOutput($sformatf("vec%0d status", i),  r_status, vecs[i].exp_status);
            checkOutput($sformatf("vec%0d data", i),    r_data,   vecs[i].exp_data);
            checkOutput($sformatf("vec%0d latency", i), lat,      vecs[i].exp_lat);
            if (vecs[i].op == CMD_WRITE) begin
                checkOutput($sformatf("vec%0d awaddr", i),      got_awaddr,          vecs[i].addr);
                checkOutput($sformatf("vec%0d wdata", i),       got_wdata,           vecs[i].data);
                checkOutput($sformatf("vec%0d awvalid cyc", i), aw_high_total - aw0, vecs[i].exp_aw_hi);
                checkOutput($sformatf("vec%0d wvalid cyc", i),  w_high_total - w0,   vecs[i].exp_w_hi);
            end
            if (vecs[i].op == CMD_READ) begin
                checkOutput($sformatf("vec%0d araddr", i), got_araddr, vecs[i].addr);
            end
            checkOutput($sformatf("vec%0d idle after", i), cmd_ready, 1);
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0;

        // interrupt pulse before WAIT completes it at once; a WAIT with no edge times out
        intr = 1'b1;
        @(posedge clk);
        #1;
        intr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(CMD_WAIT, 32'h0, 32'h0, lat, r_data, r_status);
        checkOutput("wait pend status",  r_status, ST_OKAY);
        checkOutput("wait pend latency", lat,      2);
        applyStimulus(CMD_WAIT, 32'h0, 32'h0, lat, r_data, r_status);
        checkOutput("wait tmo status",   r_status, ST_TIMEOUT);
        checkOutput("wait tmo latency",  lat,      17);
        checkOutput("wait tmo data",     r_data,   0);

        // CLR coinciding with a rising edge leaves the interrupt pending; a held level is one edge
        intr = 1'b1;
        applyStimulus(CMD_CLR, 32'h0, 32'h0, lat, r_data, r_status);
        checkOutput("clr+edge status",   r_status, ST_OKAY);
        applyStimulus(CMD_WAIT, 32'h0, 32'h0, lat, r_data, r_status);
        checkOutput("edge wins status",  r_status, ST_OKAY);
        checkOutput("edge wins latency", lat,      2);
        applyStimulus(CMD_WAIT, 32'h0, 32'h0, lat, r_data, r_status);
        checkOutput("held level status", r_status, ST_TIMEOUT);
        intr = 1'b0;

        // a CLR on its own discards an earlier pulse
        @(posedge clk);
        #1;
        intr = 1'b1;
        @(posedge clk);
        #1;
        intr = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(CMD_CLR, 32'h0, 32'h0, lat, r_data, r_status);
        applyStimulus(CMD_WAIT, 32'h0, 32'h0, lat, r_data, r_status);
        checkOutput("clr discards status",  r_status, ST_TIMEOUT);
        checkOutput("clr discards latency", lat,      17);

        // reset while AW/W are stalled abandons the write without a response
        aw_delay = 20;
        w_delay  = 20;
        cmd_valid = 1'b1;
        cmd_op    = CMD_WRITE;
        cmd_addr  = REG_SOFTRST;
        cmd_data  = 32'h1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre-reset awvalid", awvalid, 1);
        checkOutput("pre-reset busy",    busy,    1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid reset valids",    {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        checkOutput("mid reset busy",      busy,      0);
        checkOutput("mid reset cmd_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        aw_delay = 0;
        w_delay  = 0;
        @(posedge clk);
        #1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || awvalid || wvalid || busy) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("abandoned write quiet", seen, 0);

        // response held stable while the consumer stalls
        rsp_ready = 1'b0;
        slv_rdata = 32'h1357_9BDF;
        slv_rresp = ST_OKAY;
        applyStimulus(CMD_READ, REG_RESULT, 32'h0, lat, r_data, r_status);
        checkOutput("stall latency", lat,    3);
        checkOutput("stall data",    r_data, 32'h1357_9BDF);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall hold %0d", i), {rsp_valid, rsp_status, rsp_data}, {1'b1, ST_OKAY, 32'h1357_9BDF});
        end
        checkOutput("stall cmd_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall release valid", rsp_valid, 0);
        checkOutput("stall release ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
